// File: rtl/chacha20_pkg.sv
// Shared types and widths for the ChaCha20 core and its stream sequencer.
package chacha20_pkg;

  localparam int KEY_W   = 256;
  localparam int NONCE_W = 96;
  localparam int CTR_W   = 32;
  localparam int BLK_W   = 512;

  // "expand 32-byte k" words, first row of the ChaCha state
  localparam logic [31:0] CHACHA_C0 = 32'h61707865;
  localparam logic [31:0] CHACHA_C1 = 32'h3320646e;
  localparam logic [31:0] CHACHA_C2 = 32'h79622d32;
  localparam logic [31:0] CHACHA_C3 = 32'h6b206574;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/chacha20_stream_ctrl.sv
// Drives a single ChaCha20 core across a multi-block message, one block in
// flight, with a per-block completion watchdog.
module chacha20_stream_ctrl
  import chacha20_pkg::*;
#(
  parameter int NBLK_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [KEY_W-1:0]   cfg_key,
  input  logic [NONCE_W-1:0] cfg_nonce,
  input  logic [CTR_W-1:0]   cfg_counter,
  input  logic [NBLK_W-1:0]  cfg_nblocks,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLK_W-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLK_W-1:0]   out_data,
  output logic               out_last,
  output logic               msg_done,
  output logic               err_wrap,
  output logic               err_timeout,
  output logic               busy,
  output logic               core_reset,
  output logic [KEY_W-1:0]   core_key,
  output logic [NONCE_W-1:0] core_nonce,
  output logic [CTR_W-1:0]   core_counter,
  output logic [BLK_W-1:0]   core_plaintext,
  input  logic [BLK_W-1:0]   core_ciphertext,
  input  logic               core_done
);

  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW1    = CTR_W + 1;

  state_t              state, state_nxt;
  logic [NBLK_W-1:0]   remaining;
  logic [TCNT_W-1:0]   tcnt;
  logic [CTR_W:0]      end_ctr;
  logic                nblk_zero;
  logic                cfg_wrap;
  logic                timeout_hit;
  logic                last_blk;
  logic                out_hs;

  // Counter of the final block, one bit wider so a wrap shows up in the MSB
  assign end_ctr     = {1'b0, cfg_counter} + CW1'(cfg_nblocks) - CW1'(1);
  assign nblk_zero   = (cfg_nblocks == '0);
  assign cfg_wrap    = !nblk_zero && end_ctr[CTR_W];
  assign timeout_hit = (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));
  assign last_blk    = (remaining == NBLK_W'(1));
  assign out_hs      = out_valid && out_ready;

  assign cfg_ready  = (state == IDLE);
  assign in_ready   = (state == LOAD);
  assign busy       = (state != IDLE);
  assign core_reset = (state != RUN);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cfg_valid && !cfg_wrap && !nblk_zero) state_nxt = LOAD;
      LOAD: if (in_valid) state_nxt = RUN;
      RUN: begin
        // done wins over a simultaneous watchdog expiry
        if (core_done)        state_nxt = OUT;
        else if (timeout_hit) state_nxt = IDLE;
      end
      OUT: if (out_hs) state_nxt = last_blk ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      out_data       <= '0;
      msg_done       <= 1'b0;
      err_wrap       <= 1'b0;
      err_timeout    <= 1'b0;
      core_key       <= '0;
      core_nonce     <= '0;
      core_counter   <= '0;
      core_plaintext <= '0;
      remaining      <= '0;
      tcnt           <= '0;
    end else begin
      msg_done    <= 1'b0;
      err_wrap    <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            if (cfg_wrap) begin
              err_wrap <= 1'b1;
            end else if (nblk_zero) begin
              msg_done <= 1'b1;
            end else begin
              core_key     <= cfg_key;
              core_nonce   <= cfg_nonce;
              core_counter <= cfg_counter;
              remaining    <= cfg_nblocks;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            core_plaintext <= in_data;
            tcnt           <= '0;
          end
        end
        RUN: begin
          tcnt <= tcnt + TCNT_W'(1);
          if (core_done) begin
            out_data  <= core_ciphertext;
            out_valid <= 1'b1;
            out_last  <= last_blk;
          end else if (timeout_hit) begin
            err_timeout <= 1'b1;
          end
        end
        OUT: begin
          if (out_hs) begin
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            remaining    <= remaining - NBLK_W'(1);
            core_counter <= core_counter + CTR_W'(1);
            if (last_blk) msg_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha20_stream_ctrl.sv
// Directed bench for chacha20_stream_ctrl with a fixed-latency XOR core stub.
module tb_chacha20_stream_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [255:0] cfg_key;
  logic [95:0]  cfg_nonce;
  logic [31:0]  cfg_counter;
  logic [15:0]  cfg_nblocks;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_data;
  logic         out_last;
  logic         msg_done;
  logic         err_wrap;
  logic         err_timeout;
  logic         busy;
  logic         core_reset;
  logic [255:0] core_key;
  logic [95:0]  core_nonce;
  logic [31:0]  core_counter;
  logic [511:0] core_plaintext;
  logic [511:0] core_ciphertext;
  logic         core_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chacha20_stream_ctrl #(.NBLK_W(16), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_key(cfg_key),
    .cfg_nonce(cfg_nonce), .cfg_counter(cfg_counter), .cfg_nblocks(cfg_nblocks),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .msg_done(msg_done), .err_wrap(err_wrap),
    .err_timeout(err_timeout), .busy(busy), .core_reset(core_reset),
    .core_key(core_key), .core_nonce(core_nonce), .core_counter(core_counter),
    .core_plaintext(core_plaintext), .core_ciphertext(core_ciphertext),
    .core_done(core_done)
  );

  // Core stub: done 22 cycles after core_reset falls
  logic [5:0] scnt;
  logic       stub_en;
  always_ff @(posedge clk) begin
    if (core_reset)          scnt <= '0;
    else if (scnt != 6'd63)  scnt <= scnt + 6'd1;
  end
  assign core_done       = stub_en && !core_reset && (scnt == 6'd22);
  assign core_ciphertext = core_plaintext ^ {16{core_counter}};

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_cfg(input logic [31:0] ctr, input logic [15:0] nblk);
    cfg_valid   = 1'b1;
    cfg_counter = ctr;
    cfg_nblocks = nblk;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic send_block(input logic [511:0] d);
    int n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_block(input logic [511:0] exp, input logic exp_last, input int stall);
    int n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    chk("out_valid_wait", out_valid, 1);
    chk("out_data", out_data, exp);
    chk("out_last", out_last, exp_last);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_data", out_data, exp);
      chk("stall_valid", out_valid, 1);
      chk("stall_core_reset", core_reset, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("msg_done", msg_done, exp_last);
    chk("out_valid_clr", out_valid, 0);
  endtask

  initial begin
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_key   = {8{32'hA5A5_0000}} ^ 256'h1234;
    cfg_nonce = 96'hDEAD_BEEF_0000_0001_CAFE_F00D;
    cfg_counter = '0;
    cfg_nblocks = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    stub_en   = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_core_counter", core_counter, 0);
    chk("rst_core_key", core_key, 0);
    reset = 1'b0;
    @(negedge clk);

    // single block
    do_cfg(32'h1, 16'd1);
    chk("s_busy", busy, 1);
    chk("s_in_ready", in_ready, 1);
    chk("s_cfg_ready", cfg_ready, 0);
    chk("s_core_key", core_key, {8{32'hA5A5_0000}} ^ 256'h1234);
    chk("s_core_nonce", core_nonce, 96'hDEAD_BEEF_0000_0001_CAFE_F00D);
    chk("s_core_counter", core_counter, 32'h1);
    send_block('0);
    chk("s_run_core_reset", core_reset, 0);
    get_block({16{32'h0000_0001}}, 1'b1, 0);
    chk("s_idle", busy, 0);

    // three blocks, stall on block 2
    do_cfg(32'h10, 16'd3);
    send_block({512{1'b1}});
    get_block({16{32'hFFFF_FFEF}}, 1'b0, 0);
    send_block({512{1'b1}});
    get_block({16{32'hFFFF_FFEE}}, 1'b0, 5);
    send_block({512{1'b1}});
    get_block({16{32'hFFFF_FFED}}, 1'b1, 0);
    chk("m_counter_end", core_counter, 32'h13);

    // counter wrap rejected, then accepted with one block
    do_cfg(32'hFFFF_FFFF, 16'd2);
    chk("w_err_wrap", err_wrap, 1);
    chk("w_busy", busy, 0);
    chk("w_core_counter", core_counter, 32'h13);
    @(negedge clk);
    chk("w_err_wrap_pulse", err_wrap, 0);
    do_cfg(32'hFFFF_FFFF, 16'd1);
    chk("w1_err_wrap", err_wrap, 0);
    chk("w1_busy", busy, 1);
    send_block('0);
    get_block({16{32'hFFFF_FFFF}}, 1'b1, 0);

    // zero-length message
    do_cfg(32'h7, 16'd0);
    chk("z_msg_done", msg_done, 1);
    chk("z_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("z_in_ready", in_ready, 0);
      chk("z_msg_done_pulse", msg_done, 0);
    end

    // watchdog: core never finishes
    stub_en = 1'b0;
    do_cfg(32'h20, 16'd1);
    send_block('0);
    begin
      int n = 0;
      while (!err_timeout && n < 200) begin @(negedge clk); n++; end
      chk("t_err_timeout", err_timeout, 1);
      chk("t_cycles", n, 64);
    end
    chk("t_busy", busy, 0);
    chk("t_core_reset", core_reset, 1);
    chk("t_out_valid", out_valid, 0);
    @(negedge clk);
    chk("t_pulse", err_timeout, 0);
    stub_en = 1'b1;

    // reset mid-RUN, then a fresh message
    do_cfg(32'h40, 16'd2);
    send_block({16{32'h1234_5678}});
    repeat (5) @(negedge clk);
    chk("r_in_run", core_reset, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("r_busy", busy, 0);
    chk("r_core_reset", core_reset, 1);
    chk("r_core_counter", core_counter, 0);
    chk("r_core_plaintext", core_plaintext, 0);
    chk("r_core_key", core_key, 0);
    chk("r_out_valid", out_valid, 0);
    reset = 1'b0;
    @(negedge clk);
    do_cfg(32'h5, 16'd1);
    chk("r_cfg_accepted", busy, 1);
    send_block('0);
    get_block({16{32'h0000_0005}}, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chacha20_stream_ctrl.md
Name: chacha20_stream_ctrl

Overview:
Sequences the chacha20_ENCRYPTION core across multi-block messages. Accepts a per-message configuration (key, nonce, start counter, block count) and a stream of 512-bit plaintext blocks. Runs one core pass per block and increments the block counter. Returns ciphertext blocks on a valid/ready stream. Sits between the host DMA/stream fabric and a single core instance; it is the only agent that drives the core's inputs and reset.

Parameters:
NBLK_W, 16, width of the message block-count field
TIMEOUT_CYCLES, 64, max cycles in RUN without core_done before abort (must exceed core latency of ~22 cycles)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
cfg_valid  in  1  message config offered
cfg_ready  out  1  high only in IDLE
cfg_key  in  256  message key
cfg_nonce  in  96  message nonce
cfg_counter  in  32  counter for first block
cfg_nblocks  in  NBLK_W  blocks in message; 0 allowed
in_valid  in  1  plaintext block offered
in_ready  out  1  high only in LOAD
in_data  in  512  plaintext block
out_valid  out  1  ciphertext block held
out_ready  in  1  downstream accepts
out_data  out  512  ciphertext block
out_last  out  1  qualifies out_valid: final block of message
msg_done  out  1  1-cycle pulse after final block handshake, or after a nblocks=0 config
err_wrap  out  1  1-cycle pulse: config rejected, counter would wrap
err_timeout  out  1  1-cycle pulse: core_done not seen within TIMEOUT_CYCLES
busy  out  1  state != IDLE
core_reset  out  1  drives core reset; high except in RUN
core_key  out  256  registered key
core_nonce  out  96  registered nonce
core_counter  out  32  current block counter
core_plaintext  out  512  registered plaintext, stable for whole RUN
core_ciphertext  in  512  core result
core_done  in  1  core 1-cycle completion pulse

Behaviour:
- Reset (sync, active-high): state IDLE; core_reset=1; out_valid, out_last, msg_done, err_wrap, err_timeout, busy=0; out_data, core_key, core_nonce, core_counter, core_plaintext, block and timeout counters=0. Reset mid-message drops the in-flight block and all remaining message state.
- States: IDLE, LOAD, RUN, OUT.
- IDLE: cfg_ready=1. On cfg_valid, 33-bit check {1'b0,cfg_counter}+cfg_nblocks-1 > 32'hFFFFFFFF (only when nblocks≠0):
  - if it overflows: pulse err_wrap next cycle, stay IDLE, latch nothing.
  - if nblocks==0: pulse msg_done next cycle, stay IDLE.
  - otherwise: latch key, nonce, counter; remaining=nblocks; go LOAD.
- LOAD: in_ready=1, core_reset=1. On in_valid, latch in_data into core_plaintext, clear timeout counter, go RUN.
- RUN: core_reset=0 (core self-starts the following cycle). The timeout counter increments each cycle.
  - On core_done: capture core_ciphertext into out_data; out_valid=1; out_last=(remaining==1); go OUT; core_reset returns to 1 on the same edge.
  - If the counter reaches TIMEOUT_CYCLES before core_done: pulse err_timeout, go IDLE. No output. Unconsumed input blocks are upstream's to flush.
  - core_done in the same cycle as timeout expiry counts as done.
- OUT: hold out_data/out_last stable while out_valid && !out_ready. On handshake: out_valid=0, remaining-=1, core_counter+=1.
  - If that was the last block: pulse msg_done, go IDLE.
  - Otherwise go LOAD.
- core_done outside RUN is ignored. Inputs are never accepted in OUT; there is no overlap of blocks (one block in flight).
- Per-block latency, in_valid handshake to out_valid: 1 (LOAD→RUN) + core latency + 1 capture cycle.

Decomposition:
- chacha20_pkg: state enum (IDLE, LOAD, RUN, OUT), widths KEY_W=256, NONCE_W=96, CTR_W=32, BLK_W=512, and the four ChaCha constants shared with the core.
- Single module; no sub-module. The timeout counter is inline.

Test Plan:
Bench uses a core stub: core_done arrives 22 cycles after core_reset falls; ciphertext = plaintext ^ {16{core_counter}}.
- Single block: counter=32'h1, nblocks=1, in_data=512'h0 → out_data={16{32'h00000001}}, out_last=1, msg_done 1 cycle after handshake.
- Three blocks, counter=32'h10, plaintext all-ones, out_ready stalled 5 cycles on block 2 → outputs ~{16{32'h10}}, ~{16{32'h11}}, ~{16{32'h12}}; block 2 out_data stable during stall; out_last only on third; core_reset stays high during stall.
- Wrap: counter=32'hFFFFFFFF with nblocks=2 → err_wrap pulse, busy stays 0. Same counter with nblocks=1 → accepted, one block output.
- nblocks=0 → msg_done pulse; in_ready never asserts.
- Stub never raises core_done → err_timeout exactly TIMEOUT_CYCLES cycles after entering RUN; returns IDLE with core_reset=1. Then assert reset mid-RUN of a new message → all outputs at reset values next cycle, and a fresh config is accepted.
